// File: rtl/prf.sv
// Physical register file: 2**PRN_BITS x 64b, multi-port comb read, multi-port write.
// Optional PRF_BYPASS_EN forwards same-cycle write data to matching reads.
module prf #(
  parameter int OP_R_PORTS   = 4,
  parameter int OP_W_PORTS   = 4,
  parameter int MAX_OPERANDS = 3,
  parameter int PRN_BITS     = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_ren   [OP_R_PORTS][MAX_OPERANDS],
  input  logic [PRN_BITS-1:0] op_rprn  [OP_R_PORTS][MAX_OPERANDS],
  output logic [63:0]         op_rdata [OP_R_PORTS][MAX_OPERANDS],
  input  logic                op_wen   [OP_W_PORTS][MAX_OPERANDS],
  input  logic [PRN_BITS-1:0] op_wprn  [OP_W_PORTS][MAX_OPERANDS],
  input  logic [63:0]         op_wdata [OP_W_PORTS][MAX_OPERANDS]
);

  localparam int NREG = 2 ** PRN_BITS;

  logic [63:0] regs_q [NREG];
  logic [63:0] regs_d [NREG];

  // Later slots overwrite earlier ones: highest flat index wins.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < OP_W_PORTS; p++) begin
      for (int s = 0; s < MAX_OPERANDS; s++) begin
        if (op_wen[p][s]) begin
          regs_d[op_wprn[p][s]] = op_wdata[p][s];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // With forwarding, next-state already holds the prioritised write data.
  always_comb begin
    for (int p = 0; p < OP_R_PORTS; p++) begin
      for (int s = 0; s < MAX_OPERANDS; s++) begin
        op_rdata[p][s] = '0;
        if (rst && op_ren[p][s]) begin
`ifdef PRF_BYPASS_EN
          op_rdata[p][s] = regs_d[op_rprn[p][s]];
`else
          op_rdata[p][s] = regs_q[op_rprn[p][s]];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_prf.sv
// Randomised bench for prf against an array-based reference model.
// Directed cases cover reset, conflicts, same-cycle read and parallel writes.
module tb_prf;

  localparam int RP = 4;
  localparam int WP = 4;
  localparam int MO = 3;
  localparam int PB = 6;

  logic          clk;
  logic          rst_n;
  logic          ren   [RP][MO];
  logic [PB-1:0] rprn  [RP][MO];
  logic [63:0]   rdata [RP][MO];
  logic          wen   [WP][MO];
  logic [PB-1:0] wprn  [WP][MO];
  logic [63:0]   wdata [WP][MO];

  logic [63:0] mdl [64];
  int n_chk;
  int n_err;

  prf #(
    .OP_R_PORTS  (RP),
    .OP_W_PORTS  (WP),
    .MAX_OPERANDS(MO),
    .PRN_BITS    (PB)
  ) dut (
    .clk     (clk),
    .rst     (rst_n),
    .op_ren  (ren),
    .op_rprn (rprn),
    .op_rdata(rdata),
    .op_wen  (wen),
    .op_wprn (wprn),
    .op_wdata(wdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    for (int p = 0; p < 4; p++) begin
      for (int s = 0; s < MO; s++) begin
        ren[p][s]   = 1'b0;
        rprn[p][s]  = '0;
        wen[p][s]   = 1'b0;
        wprn[p][s]  = '0;
        wdata[p][s] = '0;
      end
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 64; i++) mdl[i] = '0;
  endtask

  // Flat-order application: the last enabled slot to touch an index wins.
  task automatic mdl_write();
    for (int f = 0; f < WP * MO; f++) begin
      if (wen[f / MO][f % MO]) mdl[wprn[f / MO][f % MO]] = wdata[f / MO][f % MO];
    end
  endtask

  function automatic logic [63:0] exp_rd(input int p, input int s);
    logic [63:0] v;
    if (!rst_n || !ren[p][s]) return '0;
    v = mdl[rprn[p][s]];
`ifdef PRF_BYPASS_EN
    for (int f = 0; f < WP * MO; f++) begin
      if (wen[f / MO][f % MO] && wprn[f / MO][f % MO] == rprn[p][s])
        v = wdata[f / MO][f % MO];
    end
`endif
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) mdl_write();
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag);
    for (int p = 0; p < RP; p++) begin
      for (int s = 0; s < MO; s++) begin
        chk($sformatf("%s[%0d][%0d]", tag, p, s), rdata[p][s], exp_rd(p, s));
      end
    end
  endtask

  task automatic rand_in();
    for (int p = 0; p < 4; p++) begin
      for (int s = 0; s < MO; s++) begin
        ren[p][s]   = 1'($urandom_range(0, 1));
        rprn[p][s]  = ($urandom_range(0, 1) == 1) ? PB'($urandom_range(0, 15))
                                                  : PB'($urandom);
        wen[p][s]   = ($urandom_range(0, 2) == 0);
        wprn[p][s]  = ($urandom_range(0, 1) == 1) ? PB'($urandom_range(0, 15))
                                                  : PB'($urandom);
        wdata[p][s] = {32'($urandom), 32'($urandom)};
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    clr_in();
    mdl_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Out of reset: everything reads zero.
    ren[0][0] = 1; rprn[0][0] = 0;
    ren[1][1] = 1; rprn[1][1] = 31;
    ren[2][2] = 1; rprn[2][2] = 63;
    #1;
    chk("init_r0", rdata[0][0], 64'h0);
    chk("init_r31", rdata[1][1], 64'h0);
    chk("init_r63", rdata[2][2], 64'h0);

    clr_in();
    wen[1][2] = 1; wprn[1][2] = 5; wdata[1][2] = 64'hDEADBEEF_00000001;
    step();
    clr_in();
    ren[3][0] = 1; rprn[3][0] = 5;
    #1;
    chk("basic_rd", rdata[3][0], 64'hDEADBEEF_00000001);

    ren[0][1] = 0; rprn[0][1] = 5;
    #1;
    chk("rd_dis", rdata[0][1], 64'h0);

    clr_in();
    wen[0][0] = 1; wprn[0][0] = 9; wdata[0][0] = 64'h11;
    wen[3][2] = 1; wprn[3][2] = 9; wdata[3][2] = 64'h33;
    step();
    clr_in();
    ren[1][0] = 1; rprn[1][0] = 9;
    #1;
    chk("conflict", rdata[1][0], 64'h33);

    clr_in();
    wen[2][0] = 1; wprn[2][0] = 7; wdata[2][0] = 64'hAA;
    step();
    wdata[2][0] = 64'hBB;
    ren[2][1] = 1; rprn[2][1] = 7;
    #1;
`ifdef PRF_BYPASS_EN
    chk("same_cyc", rdata[2][1], 64'hBB);
`else
    chk("same_cyc", rdata[2][1], 64'hAA);
`endif
    step();
    clr_in();
    ren[2][1] = 1; rprn[2][1] = 7;
    #1;
    chk("next_cyc", rdata[2][1], 64'hBB);

    clr_in();
    for (int f = 0; f < 12; f++) begin
      wen[f / MO][f % MO]   = 1;
      wprn[f / MO][f % MO]  = PB'(20 + f);
      wdata[f / MO][f % MO] = 64'h0101_0101_0101_0101 * (f + 1);
    end
    step();
    clr_in();
    for (int f = 0; f < 12; f++) begin
      ren[(11 - f) / MO][(11 - f) % MO]  = 1;
      rprn[(11 - f) / MO][(11 - f) % MO] = PB'(20 + f);
    end
    #1;
    for (int f = 0; f < 12; f++) begin
      chk($sformatf("par%0d", f), rdata[(11 - f) / MO][(11 - f) % MO],
          64'h0101_0101_0101_0101 * (f + 1));
    end

    for (int c = 0; c < 300; c++) begin
      rand_in();
      #1;
      chk_all($sformatf("rnd%0d", c));
      if (c == 150) begin
        // Asynchronous reset mid-run with writes still requested.
        #1 rst_n = 1'b0;
        mdl_clear();
        clr_in();
        for (int k = 0; k < MO; k++) begin
          wen[3][k] = 1; wprn[3][k] = PB'(k); wdata[3][k] = 64'hFFFF;
        end
        ren[0][0] = 1; rprn[0][0] = 0;
        ren[0][1] = 1; rprn[0][1] = 31;
        ren[0][2] = 1; rprn[0][2] = 63;
        ren[1][0] = 1; rprn[1][0] = 5;
        #1;
        chk("rst_r0", rdata[0][0], 64'h0);
        chk("rst_r31", rdata[0][1], 64'h0);
        chk("rst_r63", rdata[0][2], 64'h0);
        chk("rst_r5", rdata[1][0], 64'h0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < MO; k++) wen[3][k] = 0;
        ren[3][0] = 1; rprn[3][0] = 0;
        #1;
        chk("post_rst_r0", rdata[3][0], 64'h0);
        chk("post_rst_r5", rdata[1][0], 64'h0);
        chk("post_rst_r63", rdata[0][2], 64'h0);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/prf.md
PRF -- requirements
Module: prf

Interface
REQ-001 SHALL have parameter OP_R_PORTS, default 4: number of read port groups, one per functional unit.
REQ-002 SHALL have parameter OP_W_PORTS, default 4: number of write port groups, one per functional unit.
REQ-003 SHALL have parameter MAX_OPERANDS, default 3: read/write slots per port group.
REQ-004 SHALL have parameter PRN_BITS, default 6: physical register index width; register count is 2**PRN_BITS (64).
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port op_ren, input, 1 bit each, unpacked [OP_R_PORTS][MAX_OPERANDS]: per-slot read enable.
REQ-008 SHALL have port op_rprn, input, PRN_BITS each, unpacked [OP_R_PORTS][MAX_OPERANDS]: per-slot read index.
REQ-009 SHALL have port op_rdata, output, 64 bits each, unpacked [OP_R_PORTS][MAX_OPERANDS]: per-slot read data.
REQ-010 SHALL have port op_wen, input, 1 bit each, unpacked [OP_W_PORTS][MAX_OPERANDS]: per-slot write enable.
REQ-011 SHALL have port op_wprn, input, PRN_BITS each, unpacked [OP_W_PORTS][MAX_OPERANDS]: per-slot write index.
REQ-012 SHALL have port op_wdata, input, 64 bits each, unpacked [OP_W_PORTS][MAX_OPERANDS]: per-slot write data.

Function
REQ-013 SHALL hold 2**PRN_BITS registers of 64 bits; no register is hardwired to a constant.
REQ-014 SHALL read combinationally, zero cycles of latency: op_rdata[p][s] = reg[op_rprn[p][s]] when op_ren[p][s]=1.
REQ-015 SHALL drive op_rdata[p][s] = 0 when op_ren[p][s]=0.
REQ-016 SHALL update reg[op_wprn[p][s]] <= op_wdata[p][s] on the rising clk edge for every slot with op_wen[p][s]=1.
REQ-017 SHALL perform all enabled writes in the same edge; there is no stall and no handshake.
REQ-018 SHALL resolve same-cycle writes to one index: the slot with the highest flat index p*MAX_OPERANDS+s wins.
REQ-019 SHALL leave registers not addressed by any enabled write unchanged.
REQ-020 SHALL let any number of read slots access the same index simultaneously, each returning identical data.
REQ-021 SHALL, without bypass, return the pre-edge value on a same-cycle read of an index being written; the new value is visible from the next cycle.

Reset
REQ-022 SHALL, while rst=0, clear all registers to 0 asynchronously, regardless of clk.
REQ-023 SHALL, while rst=0, drive every op_rdata to 0.
REQ-024 SHALL ignore writes on any edge where rst=0.
REQ-025 SHALL, on rst asserted mid-operation, discard pending writes; state after deassertion is all-zero.

Configuration
REQ-026 SHALL support macro PRF_BYPASS_EN.
- Defined: a read slot whose op_rprn matches an enabled write slot in the same cycle returns that op_wdata combinationally, with priority per REQ-018; reset forcing per REQ-023 still applies.
- Undefined: no forwarding; behaviour per REQ-021.

Verification
REQ-027 SHALL check reset: rst=0 mid-run, then reads of PRN 0, 31 and 63 with op_ren=1 -> op_rdata=0.
REQ-028 SHALL check basic write/read:
- op_wen[1][2]=1, op_wprn=5, op_wdata=0xDEADBEEF_00000001, one edge;
- then op_ren[3][0]=1, op_rprn=5 -> 0xDEADBEEF_00000001 in the same cycle.
REQ-029 SHALL check read disable: op_ren[0][1]=0, op_rprn=5 holding nonzero data -> op_rdata[0][1]=0.
REQ-030 SHALL check write conflict: op_wen[0][0] data 0x11 and op_wen[3][2] data 0x33, both to PRN 9, same edge -> a subsequent read of PRN 9 returns 0x33.
REQ-031 SHALL check same-cycle read of PRN 7 (old value 0xAA) while writing 0xBB:
- without PRF_BYPASS_EN -> 0xAA that cycle, 0xBB the next cycle;
- with PRF_BYPASS_EN -> 0xBB that cycle.
REQ-032 SHALL check parallel writes: 12 distinct PRNs written with distinct data in one edge -> all 12 slots read back correctly the next cycle.
